// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS bus arbiter slice.
// Round-robin arbitration is enabled by defining MIPS_ARB_RR_EN.
package mips_pkg;

    localparam int unsigned ARB_AW  = 32;
    localparam int unsigned ARB_DW  = 32;
    localparam int unsigned ARB_BEW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic ARB_PORT_I = 1'b0;
    localparam logic ARB_PORT_D = 1'b1;

    localparam logic [ARB_BEW-1:0] BE_WORD = 4'b1111;

    // Command latched at grant time and replayed on the bus until accepted
    typedef struct packed {
        logic [ARB_AW-1:0]  addr;
        logic [ARB_DW-1:0]  wdata;
        logic [ARB_BEW-1:0] be;
        logic               we;
    } arb_cmd_t;

endpackage

// File: rtl/mips_arb_pick.sv
// Combinational grant selector for the I/D requesters.
// Round-robin path compiled only when MIPS_ARB_RR_EN is defined; otherwise D has fixed priority.
module mips_arb_pick
    import mips_pkg::*;
(
    input  logic elig_i_i,
    input  logic elig_d_i,
`ifdef MIPS_ARB_RR_EN
    input  logic last_i,
`endif
    output logic gnt_vld_c_o,
    output logic gnt_d_c_o
);

    always_comb begin
        gnt_vld_c_o = elig_i_i | elig_d_i;
`ifdef MIPS_ARB_RR_EN
        // On contention the port that was not granted last wins
        if (elig_i_i && elig_d_i) begin
            gnt_d_c_o = (last_i == ARB_PORT_I);
        end else begin
            gnt_d_c_o = elig_d_i;
        end
`else
        gnt_d_c_o = elig_d_i;
`endif
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-MM master port between instruction fetch (I) and load/store (D).
// Define MIPS_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module mips_bus_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 1023
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_req,
    input  logic [ARB_AW-1:0]   i_addr,
    output logic                i_done,
    output logic [ARB_DW-1:0]   i_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ARB_AW-1:0]   d_addr,
    input  logic [ARB_BEW-1:0]  d_be,
    input  logic [ARB_DW-1:0]   d_wdata,
    output logic                d_done,
    output logic [ARB_DW-1:0]   d_rdata,

    output logic                err,

    output logic [ARB_AW-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [ARB_DW-1:0]   writedata,
    output logic [ARB_BEW-1:0]  byteenable,
    input  logic                waitrequest,
    input  logic [ARB_DW-1:0]   readdata
);

    localparam int unsigned CNT_W    = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int unsigned CNT_LAST = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;
    localparam bit          TO_EN    = (MAX_WAIT != 0);

    arb_state_t         state_q,   state_d;
    logic               gnt_q,     gnt_d;
    arb_cmd_t           cmd_q,     cmd_d;
    logic               read_q,    read_d;
    logic               write_q,   write_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               i_done_q,  i_done_d;
    logic               d_done_q,  d_done_d;
    logic [ARB_DW-1:0]  i_rdata_q, i_rdata_d;
    logic [ARB_DW-1:0]  d_rdata_q, d_rdata_d;
    logic               err_q,     err_d;

    logic               elig_i;
    logic               elig_d;
    logic               gnt_vld_c;
    logic               gnt_d_c;

    // A port finishing this cycle still has its request high; keep it out of arbitration
    assign elig_i = i_req & ~i_done_q;
    assign elig_d = d_req & ~d_done_q;

`ifdef MIPS_ARB_RR_EN
    logic               last_q,    last_d;
`endif

    mips_arb_pick u_pick (
        .elig_i_i    (elig_i),
        .elig_d_i    (elig_d),
`ifdef MIPS_ARB_RR_EN
        .last_i      (last_q),
`endif
        .gnt_vld_c_o (gnt_vld_c),
        .gnt_d_c_o   (gnt_d_c)
    );

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cmd_d     = cmd_q;
        read_d    = read_q;
        write_d   = write_q;
        cnt_d     = cnt_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = 1'b0;
`ifdef MIPS_ARB_RR_EN
        last_d    = last_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (gnt_vld_c) begin
                    state_d = BUS;
                    cnt_d   = '0;
                    gnt_d   = gnt_d_c ? ARB_PORT_D : ARB_PORT_I;
`ifdef MIPS_ARB_RR_EN
                    last_d  = gnt_d_c ? ARB_PORT_D : ARB_PORT_I;
`endif
                    if (gnt_d_c) begin
                        cmd_d.addr  = d_addr;
                        cmd_d.wdata = d_wdata;
                        cmd_d.be    = d_be;
                        cmd_d.we    = d_we;
                        read_d      = ~d_we;
                        write_d     = d_we;
                    end else begin
                        cmd_d.addr  = i_addr;
                        cmd_d.wdata = '0;
                        cmd_d.be    = BE_WORD;
                        cmd_d.we    = 1'b0;
                        read_d      = 1'b1;
                        write_d     = 1'b0;
                    end
                end
            end

            BUS: begin
                if (!waitrequest) begin
                    state_d = RESP;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end else if (TO_EN && (cnt_q == CNT_W'(CNT_LAST))) begin
                    // Stalled too long: abandon the command and report an error
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    err_d   = 1'b1;
                    if (gnt_q == ARB_PORT_D) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = '0;
                    end
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
                if (gnt_q == ARB_PORT_D) begin
                    d_done_d  = 1'b1;
                    d_rdata_d = cmd_q.we ? '0 : readdata;
                end else begin
                    i_done_d  = 1'b1;
                    i_rdata_d = readdata;
                end
            end

            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= ARB_PORT_I;
            cmd_q     <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            cnt_q     <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
`ifdef MIPS_ARB_RR_EN
            last_q    <= ARB_PORT_I;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cmd_q     <= cmd_d;
            read_q    <= read_d;
            write_q   <= write_d;
            cnt_q     <= cnt_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
`ifdef MIPS_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign i_done     = i_done_q;
    assign i_rdata    = i_rdata_q;
    assign d_done     = d_done_q;
    assign d_rdata    = d_rdata_q;
    assign err        = err_q;
    assign address    = cmd_q.addr;
    assign writedata  = cmd_q.wdata;
    assign byteenable = cmd_q.be;
    assign read       = read_q;
    assign write      = write_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter (MAX_WAIT=4); expectations follow MIPS_ARB_RR_EN if defined.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef MIPS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mips_bus_arbiter #(.MAX_WAIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_done      (i_done),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_be        (d_be),
        .d_wdata     (d_wdata),
        .d_done      (d_done),
        .d_rdata     (d_rdata),
        .err         (err),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        logic        first_is_d;
        logic [31:0] first_addr;
        logic [31:0] second_addr;

        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_be = '0; d_wdata = '0; waitrequest = 1'b0; readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read",  {31'b0, read},  32'h0);
        chk("rst_write", {31'b0, write}, 32'h0);
        chk("rst_addr",  address,        32'h0);
        chk("rst_be",    {28'b0, byteenable}, 32'h0);
        chk("rst_wdata", writedata,      32'h0);
        chk("rst_done",  {30'b0, i_done, d_done}, 32'h0);
        chk("rst_err",   {31'b0, err},   32'h0);
        chk("rst_rdata", i_rdata | d_rdata, 32'h0);
        reset = 1'b0;
        step();

        // Single fetch, no stall
        i_req = 1'b1; i_addr = 32'hBFC0_0000; waitrequest = 1'b0; readdata = 32'h2402_0005;
        chk("f_c0_read", {31'b0, read}, 32'h0);
        step();
        chk("f_c1_read", {31'b0, read},  32'h1);
        chk("f_c1_write", {31'b0, write}, 32'h0);
        chk("f_c1_addr", address, 32'hBFC0_0000);
        chk("f_c1_be",   {28'b0, byteenable}, 32'hF);
        step();
        chk("f_c2_read", {31'b0, read},   32'h0);
        chk("f_c2_done", {31'b0, i_done}, 32'h0);
        step();
        chk("f_c3_done",  {31'b0, i_done}, 32'h1);
        chk("f_c3_rdata", i_rdata, 32'h2402_0005);
        chk("f_c3_err",   {31'b0, err}, 32'h0);
        i_req = 1'b0;
        step();
        chk("f_c4_done", {31'b0, i_done}, 32'h0);
        chk("f_c4_read", {31'b0, read},   32'h0);

        // Simultaneous I and D from idle: D wins (pointer says I was last), I follows in D's done cycle
        i_req = 1'b1; i_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000; d_be = 4'hF; readdata = 32'hAAAA_0001;
        step();
        chk("s_c1_addr", address, 32'h0000_2000);
        chk("s_c1_read", {31'b0, read}, 32'h1);
        step();
        step();
        chk("s_c3_ddone", {31'b0, d_done}, 32'h1);
        chk("s_c3_idone", {31'b0, i_done}, 32'h0);
        chk("s_c3_drdata", d_rdata, 32'hAAAA_0001);
        d_req = 1'b0;
        step();
        chk("s_c4_addr", address, 32'h0000_0400);
        chk("s_c4_read", {31'b0, read}, 32'h1);
        readdata = 32'hBBBB_0002;
        step();
        step();
        chk("s_c6_idone",  {31'b0, i_done}, 32'h1);
        chk("s_c6_irdata", i_rdata, 32'hBBBB_0002);
        chk("s_c6_drdata", d_rdata, 32'hAAAA_0001);
        i_req = 1'b0;
        step();

        // Stalled write: three waitrequest cycles
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1000; d_be = 4'b0011;
        d_wdata = 32'hDEAD_BEEF; waitrequest = 1'b1; readdata = 32'h1234_5678;
        step();
        chk("w_c1_write", {31'b0, write}, 32'h1);
        chk("w_c1_read",  {31'b0, read},  32'h0);
        chk("w_c1_addr",  address,   32'h0000_1000);
        chk("w_c1_be",    {28'b0, byteenable}, 32'h3);
        chk("w_c1_wdata", writedata, 32'hDEAD_BEEF);
        step();
        chk("w_c2_write", {31'b0, write}, 32'h1);
        step();
        chk("w_c3_write", {31'b0, write}, 32'h1);
        step();
        chk("w_c4_write", {31'b0, write}, 32'h1);
        chk("w_c4_wdata", writedata, 32'hDEAD_BEEF);
        waitrequest = 1'b0;
        step();
        chk("w_c5_write", {31'b0, write},  32'h0);
        chk("w_c5_done",  {31'b0, d_done}, 32'h0);
        step();
        chk("w_c6_done",  {31'b0, d_done}, 32'h1);
        chk("w_c6_rdata", d_rdata, 32'h0);
        chk("w_c6_err",   {31'b0, err}, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        step();
        chk("w_c7_done", {31'b0, d_done}, 32'h0);

        // Contention after a lone D grant: round-robin favours I, fixed priority favours D
        first_is_d  = ~RR;
        first_addr  = RR ? 32'h0000_0500 : 32'h0000_3000;
        second_addr = RR ? 32'h0000_3000 : 32'h0000_0500;
        i_req = 1'b1; i_addr = 32'h0000_0500;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_be = 4'hF; readdata = 32'h1111_0004;
        step();
        chk("m_c1_addr", address, first_addr);
        step();
        step();
        chk("m_c3_first_done", {31'b0, first_is_d ? d_done : i_done}, 32'h1);
        chk("m_c3_other_idle", {31'b0, first_is_d ? i_done : d_done}, 32'h0);
        if (first_is_d) d_req = 1'b0; else i_req = 1'b0;
        step();
        chk("m_c4_addr", address, second_addr);
        step();
        step();
        chk("m_c6_second_done", {31'b0, first_is_d ? i_done : d_done}, 32'h1);
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Timeout: waitrequest stuck high, MAX_WAIT=4
        i_req = 1'b1; i_addr = 32'h0000_0600; waitrequest = 1'b1;
        step();
        chk("t_c1_read", {31'b0, read}, 32'h1);
        step();
        step();
        step();
        chk("t_c4_read", {31'b0, read}, 32'h1);
        chk("t_c4_done", {31'b0, i_done}, 32'h0);
        step();
        chk("t_c5_read",  {31'b0, read},   32'h0);
        chk("t_c5_done",  {31'b0, i_done}, 32'h1);
        chk("t_c5_err",   {31'b0, err},    32'h1);
        chk("t_c5_rdata", i_rdata, 32'h0);
        i_req = 1'b0; waitrequest = 1'b0;
        step();
        chk("t_c6_done", {31'b0, i_done}, 32'h0);
        chk("t_c6_err",  {31'b0, err},    32'h0);

        // Reset asserted while a command is on the bus
        i_req = 1'b1; i_addr = 32'h0000_0700; waitrequest = 1'b1;
        step();
        chk("r_c1_read", {31'b0, read}, 32'h1);
        chk("r_c1_addr", address, 32'h0000_0700);
        #3 reset = 1'b1;
        #1;
        chk("r_async_read",  {31'b0, read},  32'h0);
        chk("r_async_write", {31'b0, write}, 32'h0);
        chk("r_async_addr",  address, 32'h0);
        i_req = 1'b0; waitrequest = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("r_nodone", {30'b0, i_done, d_done}, 32'h0);
        step();
        chk("r_nodone2", {30'b0, i_done, d_done}, 32'h0);
        i_req = 1'b1; i_addr = 32'h0000_0800; readdata = 32'hCAFE_0003;
        step();
        chk("r_new_read", {31'b0, read}, 32'h1);
        chk("r_new_addr", address, 32'h0000_0800);
        step();
        step();
        chk("r_new_done",  {31'b0, i_done}, 32'h1);
        chk("r_new_rdata", i_rdata, 32'hCAFE_0003);
        chk("r_new_err",   {31'b0, err}, 32'h0);
        i_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Shares the CPU's single Avalon memory-mapped master port between two internal requesters: the instruction-fetch port (I) and the load/store data port (D). It sits between the mips_cpu_bus control FSM and the external bus. It serialises requests, holds commands stable across `waitrequest`, and returns read data with a `done` pulse. It also aborts transactions that stall past a configurable limit.

## Interface
- `MAX_WAIT`, default 1023: maximum consecutive `waitrequest`-high cycles tolerated per transaction; 0 disables the timeout.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  fetch request; held high until `i_done`.
- `i_addr`  in  32  fetch address (word-aligned by requester).
- `i_done`  out  1  one-cycle pulse: fetch complete.
- `i_rdata`  out  32  fetched word; stable from `i_done` until the next `i_done`.
- `d_req`  in  1  data request; held high until `d_done`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  32  data address.
- `d_be`  in  4  byte enables.
- `d_wdata`  in  32  write data.
- `d_done`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  32  read data (0 after a write); stable until the next `d_done`.
- `err`  out  1  high with a `*_done` pulse if that transaction timed out.
- `address`  out  32  Avalon address.
- `read`  out  1  Avalon read.
- `write`  out  1  Avalon write.
- `writedata`  out  32  Avalon write data.
- `byteenable`  out  4  Avalon byte enables.
- `waitrequest`  in  1  slave stall.
- `readdata`  in  32  slave read data; valid the cycle after acceptance.

## Operation
- **FSM states:** IDLE, BUS, RESP.
- **IDLE:**
  - If any eligible request is pending, grant one, latch its address, be, wdata and we into command registers, and go to BUS.
  - A port whose `*_done` is high this cycle is not eligible.
- **BUS:**
  - `read` or `write` is high and all command outputs are driven from the latched registers.
  - Fetch always uses `byteenable`=4'b1111 and `write`=0.
  - When `waitrequest`=0 at the edge, the command is accepted: go to RESP.
- **RESP:**
  - Capture `readdata` (write: capture 0) into the granted port's rdata register.
  - Pulse that port's `done` in the next cycle; return to IDLE.
- **Timeout:**
  - The wait counter increments on each BUS cycle with `waitrequest`=1 and clears on entry to BUS.
  - When the counter reaches `MAX_WAIT` (if nonzero), drop `read`/`write`, go to IDLE, and pulse `done` with `err`=1 and rdata=0.
- **Request rules:**
  - Requests are not queued; the requester holds its inputs stable until its `done`.
  - Input changes while granted are ignored.
- **Reset values:** all outputs 0; FSM to IDLE; wait counter 0; rdata registers 0; round-robin pointer = "I last granted".

## Timing
- All outputs are registered; no combinational path from `waitrequest` or `readdata` to any output.
- **Minimum latency**, request high in cycle 0:
  - cycle 1: BUS with command on the bus;
  - cycle 2: RESP;
  - cycle 3: `done`=1 with rdata valid.
- Each `waitrequest` cycle adds 1.
- **Back-to-back:** a new grant can occur in the `done` cycle, for the other port only. The same port cannot be granted again before cycle 4.
- **Simultaneous requests:** resolved as described under Configuration.
- **Reset mid-transaction:** `read`/`write` drop immediately (asynchronous reset). No `done` is issued, and the requester must re-request.
- **Wait counter width:** $clog2(MAX_WAIT+1). The counter never wraps, because it is compared before incrementing.

## Configuration
- **Macro:** `MIPS_ARB_RR_EN`.
- **Defined:** round-robin arbitration. On simultaneous requests, the port not granted most recently wins. The pointer updates on each grant.
- **Undefined:** fixed priority, with D always winning over I. No pointer register.

## Structure
- **Shared package `mips_pkg`:**
  - `arb_state_t` (IDLE/BUS/RESP, 2-bit enum);
  - port index constants `ARB_PORT_I`=0, `ARB_PORT_D`=1;
  - `BE_WORD`=4'b1111.
- **Sub-module `mips_arb_pick`:** a combinational grant selector taking the two eligible bits and the last-grant pointer. Its round-robin path is compiled under `MIPS_ARB_RR_EN`.

## Test plan
- **Single fetch:** `i_addr`=0xBFC00000, `waitrequest`=0, readdata=0x24020005 → `read`=1 in cycle 1 only; `i_done` in cycle 3 with `i_rdata`=0x24020005, `err`=0.
- **Stalled write:** `d_we`=1, addr 0x1000, be 4'b0011, wdata 0xDEADBEEF, `waitrequest` high for 3 cycles → command stable 4 cycles; `d_done` in cycle 6; `d_rdata`=0.
- **Simultaneous I and D every cycle:**
  - with `MIPS_ARB_RR_EN`: grants alternate D, I, D, I;
  - without it: D only while `d_req` is held.
- **Timeout:** `MAX_WAIT`=4, `waitrequest` stuck at 1 → `read` drops after 4 stall cycles; `i_done`=1 with `err`=1 and `i_rdata`=0.
- **Reset during BUS:** assert `reset` mid-cycle → `read`/`write`/`address` become 0 before the next edge; no `done` is issued; after release a fresh request completes normally.
